// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and requester ids for the matrix memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BANDWIDTH  = 4;
  localparam int unsigned MEM_RD_LAT = 2;

  // Requester slots on the shared port.
  typedef enum logic [1:0] {
    REQ_OP  = 2'd0,
    REQ_A   = 2'd1,
    REQ_B   = 2'd2,
    REQ_RES = 2'd3
  } req_id_t;

  // Arbiter states.
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request at or after ptr, with wrap.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0]  w_req;
  logic [IW-1:0] w_j;

  assign w_req = i_req & i_mask;

  // Scan ptr, ptr+1, ... (mod N) and keep the first eligible request.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = IW'((32'(i_ptr) + k) % N);
      if (!o_valid && w_req[w_j]) begin
        o_valid    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port matrix memory arbiter: round-robin with burst lock, registered
// command stage and in-order read-return tagging.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = int'(REQ_RES) + 1,
  parameter int unsigned ADDR_W = ADDR_WIDTH,
  parameter int unsigned DATA_W = DATA_WIDTH * BANDWIDTH,
  parameter int unsigned RD_LAT = MEM_RD_LAT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_writedata,
  input  logic [DATA_W-1:0]       mem_readdata
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [0:0]        r_state;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_ptr;

  logic [N_REQ-1:0]  w_mask;
  logic [N_REQ-1:0]  w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_valid;
  logic [IW-1:0]     w_ptr_nxt;

  logic              w_we_sel;
  logic              w_lock_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;

  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_writedata;

  logic [RD_LAT-1:0] r_tag_v;
  logic [IW-1:0]     r_tag_id [RD_LAT];

  logic [N_REQ-1:0]  w_rvalid_nxt;
  logic [N_REQ-1:0]  r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  // Restrict eligibility to the burst owner while locked.
  always_comb begin
    w_mask = '1;
    if (r_state == ST_LOCKED) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  mem_port_arbiter_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_mask  (w_mask),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_ptr_nxt = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Select the granted requester's command fields (grant is one-hot).
  always_comb begin
    w_we_sel    = 1'b0;
    w_lock_sel  = 1'b0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_we_sel    = we[i];
        w_lock_sel  = lock[i];
        w_addr_sel  = addr[i*ADDR_W +: ADDR_W];
        w_wdata_sel = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration state: pointer advance, burst lock entry and release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_owner <= '0;
      r_ptr   <= '0;
    end else if (w_valid) begin
      r_ptr <= w_ptr_nxt;
      if (r_state == ST_ARB) begin
        if (w_lock_sel) begin
          r_state <= ST_LOCKED;
          r_owner <= w_idx;
        end
      end else if (!w_lock_sel) begin
        r_state <= ST_ARB;
      end
    end
  end

  // Registered command stage: one memory access per granted cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      r_mem_read  <= w_valid & ~w_we_sel;
      r_mem_write <= w_valid & w_we_sel;
      if (w_valid) begin
        r_mem_address   <= w_addr_sel;
        r_mem_writedata <= w_wdata_sel;
      end
    end
  end

  // Read tag pipe: stage 0 lines up with mem_read, last stage with mem_readdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_valid & ~w_we_sel;
      r_tag_id[0] <= w_idx;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // Decode the emerging tag into a one-hot return strobe.
  always_comb begin
    w_rvalid_nxt = '0;
    if (r_tag_v[RD_LAT-1]) begin
      w_rvalid_nxt[r_tag_id[RD_LAT-1]] = 1'b1;
    end
  end

  // Register returned data together with its requester strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rvalid_nxt;
      if (r_tag_v[RD_LAT-1]) begin
        r_rdata <= mem_readdata;
      end
    end
  end

  assign gnt           = w_gnt;
  assign rvalid        = r_rvalid;
  assign rdata         = r_rdata;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle synchronous RAM model.
module tb_mem_port_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req, we, lock;
  logic [63:0]  addr;
  logic [511:0] wdata;
  logic [3:0]   gnt, rvalid;
  logic [127:0] rdata;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;

  logic [127:0] mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] DEAD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_0040;
  localparam logic [127:0] NEWD = 128'h5555_AAAA_1111_2222_3333_4444_6666_7777;

  mem_port_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .we            (we),
    .lock          (lock),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: data for a read strobe appears the following cycle.
  always @(posedge clock) begin
    if (mem_read)  mem_readdata <= mem[mem_address[7:0]];
    if (mem_write) mem[mem_address[7:0]] <= mem_writedata;
  end

  function automatic logic [127:0] init_word(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1357, 16'hBEEF, a, ~a ^ 16'h0F0F, 16'h1234};
  endfunction

  task automatic clr();
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
  endtask

  task automatic put(input int i, input logic w, input logic l,
                     input logic [15:0] a, input logic [127:0] d);
    req[i] = 1'b1; we[i] = w; lock[i] = l;
    addr[i*16 +: 16] = a;
    wdata[i*128 +: 128] = d;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    n_cmp++; if (gnt !== 4'b0)        begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_cmp++; if (rvalid !== 4'b0)     begin n_bad++; $display("FAIL reset_rvalid got=%b want=0000", rvalid); end
    n_cmp++; if (rdata !== '0)        begin n_bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    n_cmp++; if (mem_read !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0)  begin n_bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
    n_cmp++; if (mem_address !== '0)  begin n_bad++; $display("FAIL reset_mem_address got=%h want=0", mem_address); end
    n_cmp++; if (mem_writedata !== '0) begin n_bad++; $display("FAIL reset_mem_writedata got=%h want=0", mem_writedata); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    clr(); put(1, 1'b0, 1'b0, 16'h0010, '0);
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL single_gnt got=%b want=0010", gnt); end
    next_cycle(); clr();
    @(negedge clock);
    n_cmp++; if (mem_read !== 1'b1)       begin n_bad++; $display("FAIL single_mem_read got=%b want=1", mem_read); end
    n_cmp++; if (mem_write !== 1'b0)      begin n_bad++; $display("FAIL single_mem_write got=%b want=0", mem_write); end
    n_cmp++; if (mem_address !== 16'h0010) begin n_bad++; $display("FAIL single_mem_address got=%h want=0010", mem_address); end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin next_cycle(); @(negedge clock); end
      n_cmp++;
      if (rvalid !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
        n_bad++; $display("FAIL single_rvalid c%0d got=%b want=%b", c, rvalid, (c == 3) ? 4'b0010 : 4'b0000);
      end
      if (c == 3) begin
        n_cmp++;
        if (rdata !== init_word(16'h0010)) begin
          n_bad++; $display("FAIL single_rdata got=%h want=%h", rdata, init_word(16'h0010));
        end
      end
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         id [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      clr();
      if (c < 5) begin
        for (int i = 0; i < 4; i++) put(i, 1'b1, 1'b0, 16'h0080 + 16'(i), {4{32'hC0DE_0000 + 32'(i)}});
      end
      @(negedge clock);
      if (c < 5) begin
        n_cmp++;
        if (gnt !== eg[c]) begin n_bad++; $display("FAIL rr_gnt c%0d got=%b want=%b", c, gnt, eg[c]); end
      end
      if (c > 0) begin
        n_cmp++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
          n_bad++; $display("FAIL rr_strobe c%0d got=w%b r%b want=w1 r0", c, mem_write, mem_read);
        end
        n_cmp++;
        if (mem_address !== 16'h0080 + 16'(id[c-1]) ||
            mem_writedata !== {4{32'hC0DE_0000 + 32'(id[c-1])}}) begin
          n_bad++; $display("FAIL rr_cmd c%0d got=%h/%h want id %0d", c, mem_address, mem_writedata, id[c-1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_burst_lock();
    logic [3:0]  eg [10] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0]  er [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                             4'b0010, 4'b0010, 4'b0100, 4'b0000};
    logic [15:0] ea [10] = '{16'h0, 16'h0, 16'h0, 16'h0020, 16'h0021, 16'h0,
                             16'h0022, 16'h0023, 16'h0030, 16'h0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clr();
      case (c)
        0: put(1, 1'b0, 1'b1, 16'h0020, '0);
        1: put(1, 1'b0, 1'b1, 16'h0021, '0);
        3: put(1, 1'b0, 1'b1, 16'h0022, '0);
        4: put(1, 1'b0, 1'b0, 16'h0023, '0);
        default: ;
      endcase
      if (c <= 5) put(2, 1'b0, 1'b0, 16'h0030, '0);
      @(negedge clock);
      n_cmp++;
      if (gnt !== eg[c]) begin n_bad++; $display("FAIL burst_gnt c%0d got=%b want=%b", c, gnt, eg[c]); end
      if (c > 0) begin
        n_cmp++;
        if (mem_read !== (eg[c-1] != 4'b0)) begin
          n_bad++; $display("FAIL burst_mem_read c%0d got=%b want=%b", c, mem_read, eg[c-1] != 4'b0);
        end
      end
      n_cmp++;
      if (rvalid !== er[c]) begin n_bad++; $display("FAIL burst_rvalid c%0d got=%b want=%b", c, rvalid, er[c]); end
      if (er[c] != 4'b0) begin
        n_cmp++;
        if (rdata !== init_word(ea[c])) begin
          n_bad++; $display("FAIL burst_rdata c%0d got=%h want=%h", c, rdata, init_word(ea[c]));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mixed_traffic();
    logic [3:0] eg [7] = '{4'b1000, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clr();
      if (c == 0) put(3, 1'b1, 1'b0, 16'h0040, DEAD);
      if (c == 1) put(1, 1'b0, 1'b0, 16'h0040, '0);
      @(negedge clock);
      n_cmp++;
      if (gnt !== eg[c]) begin n_bad++; $display("FAIL mixed_gnt c%0d got=%b want=%b", c, gnt, eg[c]); end
      if (c == 1) begin
        n_cmp++;
        if (mem_write !== 1'b1 || mem_address !== 16'h0040 || mem_writedata !== DEAD) begin
          n_bad++; $display("FAIL mixed_write got=w%b %h %h want=w1 0040 %h", mem_write, mem_address, mem_writedata, DEAD);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h0040) begin
          n_bad++; $display("FAIL mixed_read got=r%b w%b %h want=r1 w0 0040", mem_read, mem_write, mem_address);
        end
      end
      n_cmp++;
      if (rvalid !== ((c == 4) ? 4'b0010 : 4'b0000)) begin
        n_bad++; $display("FAIL mixed_rvalid c%0d got=%b want=%b", c, rvalid, (c == 4) ? 4'b0010 : 4'b0000);
      end
      if (c == 4) begin
        n_cmp++;
        if (rdata !== DEAD) begin n_bad++; $display("FAIL mixed_rdata got=%h want=%h", rdata, DEAD); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  eg [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
    logic [3:0]  er [8] = '{4'b0, 4'b0, 4'b0, 4'b0010, 4'b0100, 4'b0010, 4'b0, 4'b0};
    logic [15:0] ea [8] = '{16'h0, 16'h0, 16'h0, 16'h0011, 16'h0012, 16'h0013, 16'h0, 16'h0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clr();
      case (c)
        0: put(1, 1'b0, 1'b0, 16'h0011, '0);
        1: put(2, 1'b0, 1'b0, 16'h0012, '0);
        2: put(1, 1'b0, 1'b0, 16'h0013, '0);
        3: put(3, 1'b1, 1'b0, 16'h0013, NEWD);
        default: ;
      endcase
      @(negedge clock);
      n_cmp++;
      if (gnt !== eg[c]) begin n_bad++; $display("FAIL b2b_gnt c%0d got=%b want=%b", c, gnt, eg[c]); end
      n_cmp++;
      if (rvalid !== er[c]) begin n_bad++; $display("FAIL b2b_rvalid c%0d got=%b want=%b", c, rvalid, er[c]); end
      if (er[c] != 4'b0) begin
        n_cmp++;
        if (rdata !== init_word(ea[c])) begin
          n_bad++; $display("FAIL b2b_rdata c%0d got=%h want=%h", c, rdata, init_word(ea[c]));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    clr(); put(1, 1'b0, 1'b1, 16'h0010, '0);
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL midrst_gnt got=%b want=0010", gnt); end
    next_cycle();
    clr();
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL midrst_strobe got=%b want=0", mem_read); end
    next_cycle(); next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_cmp++;
      if (rvalid !== 4'b0) begin n_bad++; $display("FAIL midrst_rvalid c%0d got=%b want=0000", c, rvalid); end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) put(i, 1'b0, 1'b0, 16'h0010 + 16'(i), '0);
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_first_gnt got=%b want=0001", gnt); end
    next_cycle(); clr();
    repeat (5) next_cycle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = init_word(16'(a));
    clr();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_mixed_traffic();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
